// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule tables, shift schedule and state encodings
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // PC-1: entry i names the key bit (1 = MSB) that lands in C||D bit i+1
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry i names the C||D bit (1 = MSB) that lands in subkey bit i+1
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Encryption left-shift amounts S[1..16], stored at index 0..15
  localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // PC-1 from the 64-bit key (bit 63 = FIPS bit 1) to 56-bit C||D; parity bits drop out
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1_TAB[6'(i)])];
    end
    return cd;
  endfunction

  // Right rotation of a 28-bit half by one or two places (undoes an encryption left shift)
  function automatic logic [27:0] rotr(input logic [27:0] v, input logic by_two);
    return by_two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - PC-2 compression permutation, 56-bit C||D to 48-bit subkey
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  // Pure wiring: subkey bit i+1 (MSB first) taken from C||D bit PC2_TAB[i]
  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[6'(47 - i)] = cd[6'(56 - PC2_TAB[6'(i)])];
    end
  end

endmodule

// File: rtl/des_dec_key_sched.sv
// rtl/des_dec_key_sched.sv - DES decryption-order subkey generator with valid/ready output
module des_dec_key_sched
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key_in,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        done
);

  state_t      state, state_nxt;
  logic [27:0] c, d;
  logic [3:0]  idx;
  logic        accept;
  logic        hs;
  logic        last;
  logic        by_two;

  // C0||D0 already equals C16||D16 (total shift is 28), so K16 comes straight from PC-1
  assign accept = (state == ST_IDLE) && start;
  assign hs     = (state == ST_RUN) && subkey_ready;
  assign last   = (idx == 4'd15);
  // Step from C(16-r) to C(15-r) undoes the encryption shift S[16-r]
  assign by_two = (SHIFT_TAB[4'(4'd15 - idx)] == 2);

  assign busy         = (state == ST_RUN);
  assign subkey_valid = (state == ST_RUN);
  assign done         = (state == ST_DONE);
  assign round_idx    = idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one DONE cycle after the final handshake, then back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (hs && last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // C/D halves and round counter: load on accept, step right on each non-final handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c   <= '0;
      d   <= '0;
      idx <= '0;
    end else if (accept) begin
      {c, d} <= pc1(key_in);
      idx    <= '0;
    end else if (hs && !last) begin
      c   <= rotr(c, by_two);
      d   <= rotr(d, by_two);
      idx <= idx + 4'd1;
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c, d}),
    .subkey (subkey)
  );

endmodule

// File: doc/des_dec_key_sched.md
DES_DEC_KEY_SCHED -- requirements
Module: des_dec_key_sched

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: start  input  1  request to begin a schedule; sampled only in IDLE.
REQ-004 SHALL have port: key_in  input  64  DES key; key_in[63] = FIPS bit 1; parity bits ignored.
REQ-005 SHALL have port: busy  output  1  high from start acceptance until the last subkey handshake.
REQ-006 SHALL have port: subkey_valid  output  1  subkey and round_idx are valid.
REQ-007 SHALL have port: subkey_ready  input  1  consumer accepts the subkey when high with subkey_valid.
REQ-008 SHALL have port: subkey  output  48  round subkey; subkey[47] = PC-2 output bit 1.
REQ-009 SHALL have port: round_idx  output  4  decryption round minus 1 (0..15); subkey carries K(16-round_idx).
REQ-010 SHALL have port: done  output  1  one-cycle pulse after the final handshake.

Function
REQ-011 SHALL emit the 16 subkeys in decryption order K16, K15, ..., K1, one per accepted handshake.
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on handshake at round_idx 15; DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL register C||D = PC-1(key_in) (FIPS 46-3 table, C = upper 28 bits) on the clock edge that accepts start.
REQ-014 SHALL assert subkey_valid in the cycle immediately after start is accepted, with round_idx = 0 and subkey = PC-2(C0||D0) = K16 (latency 1).
REQ-015 SHALL, on each handshake (subkey_valid & subkey_ready) with round_idx = r < 15, rotate C and D right independently by S[16-r] and increment round_idx, where S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-016 SHALL hold subkey, round_idx and subkey_valid stable while subkey_valid is high and subkey_ready is low.
REQ-017 SHALL sustain one subkey per cycle when subkey_ready is held high (16 cycles for a full schedule).
REQ-018 SHALL deassert subkey_valid and assert done in the cycle after the handshake at round_idx 15.
REQ-019 SHALL ignore start while in RUN or DONE; key_in changes after acceptance SHALL NOT affect the schedule.
REQ-020 SHALL compute subkey combinationally from the C/D registers via PC-2 (FIPS 46-3 table).
REQ-021 SHALL accept a new start in the cycle that IDLE is re-entered, without dead cycles beyond DONE.

Reset
REQ-022 SHALL drive, while rst_n is low: state = IDLE, busy = 0, subkey_valid = 0, done = 0, round_idx = 0, C/D = 0 (hence subkey = 0).
REQ-023 SHALL abandon any in-progress schedule when reset is asserted mid-RUN, with no further subkey_valid until a new start.
REQ-024 SHALL leave reset on a rising clock edge with rst_n high; start on that edge SHALL be accepted.

Structure
REQ-025 SHALL place the PC-1 and PC-2 tables, the shift schedule S, and state encodings in a shared package des_pkg.
REQ-026 SHALL use one sub-module, des_pc2 (56-to-48 combinational permutation); PC-1 and rotation are inline.
REQ-027 SHALL fit in 120-400 lines of RTL; no memories, and no multipliers.

Verification
REQ-028 SHALL test: key_in = 133457799BBCDFF1, start, subkey_ready = 1 -> round_idx 0 subkey CB3D8B0E17F5, round_idx 14 subkey 79AED9DBC9E5, round_idx 15 subkey 1B02EFFC7072, done the next cycle.
REQ-029 SHALL test: same key, subkey_ready low for 3 cycles at round_idx 5 -> subkey/round_idx held unchanged, sequence then resumes identically to REQ-028.
REQ-030 SHALL test: start pulsed again at round_idx 7 with key_in = 0000000000000000 -> ignored; remaining subkeys match REQ-028.
REQ-031 SHALL test: rst_n low at round_idx 9 -> all outputs 0 within the reset assertion; new start yields K16 = CB3D8B0E17F5 at round_idx 0.
REQ-032 SHALL test: random keys, random subkey_ready -> all 16 subkeys match a reference model encryption schedule reversed; round_idx 0..15 consecutively.
